// File: rtl/mcdt_arbiter.sv
// MCDT channel scheduler: picks one of three show-ahead FIFOs per burst (round-robin
// or fixed priority), pops up to BURST_LEN words and drives a registered valid/ready port.
module mcdt_arbiter #(
  parameter int DW        = 32,
  parameter int BURST_LEN = 4
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic [DW-1:0] ch0_data_i,
  input  logic          ch0_val_i,
  output logic          ch0_pop_o,
  input  logic          ch0_en_i,
  input  logic [1:0]    ch0_prio_i,
  input  logic [DW-1:0] ch1_data_i,
  input  logic          ch1_val_i,
  output logic          ch1_pop_o,
  input  logic          ch1_en_i,
  input  logic [1:0]    ch1_prio_i,
  input  logic [DW-1:0] ch2_data_i,
  input  logic          ch2_val_i,
  output logic          ch2_pop_o,
  input  logic          ch2_en_i,
  input  logic [1:0]    ch2_prio_i,
  input  logic          arb_mode_i,
  output logic [DW-1:0] mcdt_data_o,
  output logic          mcdt_val_o,
  output logic [1:0]    mcdt_id_o,
  input  logic          mcdt_rdy_i
);

  localparam int            CW        = $clog2(BURST_LEN) + 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state, state_nxt;
  logic [1:0]      rr_ptr, gnt_id, win_id, best_p;
  logic [CW-1:0]   beat_cnt;
  logic [3:0]      req;
  logic [3:0][1:0] prio;
  logic [2:0]      idx;
  logic [DW-1:0]   gnt_data;
  logic [2:0]      pops;
  logic            found, can_load, pop, rel;

  // Slot 3 is a constant non-requester so a 2-bit gnt_id can index safely.
  assign req  = {1'b0, ch2_val_i & ch2_en_i, ch1_val_i & ch1_en_i, ch0_val_i & ch0_en_i};
  assign prio = {2'd0, ch2_prio_i, ch1_prio_i, ch0_prio_i};

  // Fixed mode: strict '>' keeps the lowest index on ties.
  // RR mode: scan backwards so the candidate closest to rr_ptr is written last.
  always_comb begin
    win_id = 2'd0;
    best_p = 2'd0;
    found  = 1'b0;
    idx    = 3'd0;
    if (arb_mode_i) begin
      for (int i = 0; i < 3; i++)
        if (req[i] && (!found || prio[i] > best_p)) begin
          win_id = 2'(i);
          best_p = prio[i];
          found  = 1'b1;
        end
    end else begin
      for (int i = 2; i >= 0; i--) begin
        idx = {1'b0, rr_ptr} + 3'(i);
        if (idx >= 3'd3) idx = idx - 3'd3;
        if (req[idx[1:0]]) win_id = idx[1:0];
      end
    end
  end

  always_comb begin
    case (gnt_id)
      2'd0:    gnt_data = ch0_data_i;
      2'd1:    gnt_data = ch1_data_i;
      default: gnt_data = ch2_data_i;
    endcase
  end

  assign can_load = !mcdt_val_o || mcdt_rdy_i;
  assign pop      = (state == GRANT) && req[gnt_id] && can_load;
  // A stall alone never releases; only an empty/disabled channel or the final beat does.
  assign rel      = (state == GRANT) && (!req[gnt_id] || (pop && beat_cnt == LAST_BEAT));

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req) state_nxt = GRANT;
      GRANT:   if (rel)  state_nxt = IDLE;
      default:           state_nxt = IDLE;
    endcase
  end

  for (genvar n = 0; n < 3; n++) begin : g_pop
    assign pops[n] = pop && (gnt_id == 2'(n));
  end

  always_comb begin
    ch0_pop_o = pops[0];
    ch1_pop_o = pops[1];
    ch2_pop_o = pops[2];
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rr_ptr      <= 2'd0;
      gnt_id      <= 2'd0;
      beat_cnt    <= '0;
      mcdt_data_o <= '0;
      mcdt_val_o  <= 1'b0;
      mcdt_id_o   <= 2'd0;
    end else begin
      if (state == IDLE && |req) begin
        gnt_id   <= win_id;
        beat_cnt <= '0;
      end
      if (pop) beat_cnt <= beat_cnt + CW'(1);
      if (rel) rr_ptr <= (gnt_id == 2'd2) ? 2'd0 : gnt_id + 2'd1;
      if (pop) begin
        mcdt_data_o <= gnt_data;
        mcdt_id_o   <= gnt_id;
        mcdt_val_o  <= 1'b1;
      end else if (mcdt_rdy_i) begin
        mcdt_val_o  <= 1'b0;
      end
    end
  end

endmodule
